line_fill_buffer: RTL and testbench

//   Write-side counterpart of the cache read-word select path: assembles one
//   8-word cache line from a critical-word-first wrapped memory burst.

---
 rtl/line_fill_buffer.sv | 136 +++++++++++++
 tb/tb_line_fill_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_fill_buffer
// Brief    : Assembles one cache line from a critical-word-first wrapped
//            memory burst. Forwards the critical word as soon as it arrives,
//            then presents the whole line for a single-cycle array write.
// Revision : 1.0 - initial release
// ============================================================================
module line_fill_buffer #(
    parameter int WORDS = 8,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                fill_start,
    input  logic [AW-1:0]       fill_addr,
    output logic                fill_busy,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_rdy,
    input  logic                mem_rvalid,
    input  logic [DW-1:0]       mem_rdata,
    output logic                crit_valid,
    output logic [DW-1:0]       crit_word,
    output logic                line_valid,
    output logic [WORDS*DW-1:0] line_data,
    output logic [AW-1:0]       line_addr
);

    // Address split: | line base | word offset | byte-in-word |
    localparam int OW  = $clog2(WORDS);
    localparam int BW  = $clog2(DW / 8);
    localparam int LSB = OW + BW;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RECV = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [OW-1:0] c_LAST_CNT = OW'(WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [OW-1:0]     r_offset;
    logic [OW-1:0]     r_cnt;
    logic [AW-LSB-1:0] r_base;
    logic [DW-1:0]     r_line [WORDS];
    logic [DW-1:0]     r_crit_word;
    logic              r_crit_valid;

    logic              w_accept;
    logic              w_beat;
    logic              w_last;
    logic [OW-1:0]     w_idx;
    logic              w_unused;

    // Byte-within-word bits of the miss address carry no information here.
    assign w_unused = ^fill_addr[BW-1:0];

    assign w_accept = (r_state == c_IDLE) && fill_start;
    assign w_beat   = (r_state == c_RECV) && mem_rvalid;
    assign w_last   = w_beat && (r_cnt == c_LAST_CNT);
    // Wrapped word index: OW-bit add wraps modulo WORDS for free.
    assign w_idx    = r_offset + r_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> REQ -> RECV -> DONE -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (fill_start) w_next_state = c_REQ;
            c_REQ:   if (mem_rdy)    w_next_state = c_RECV;
            c_RECV:  if (w_last)     w_next_state = c_DONE;
            c_DONE:                  w_next_state = c_IDLE;
            default:                 w_next_state = c_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        fill_busy  = (r_state != c_IDLE);
        mem_req    = (r_state == c_REQ);
        line_valid = (r_state == c_DONE);
    end

    // Datapath: latch miss address, steer beats into the line, capture critical word
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_offset     <= '0;
            r_base       <= '0;
            r_cnt        <= '0;
            r_crit_word  <= '0;
            r_crit_valid <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                r_line[k] <= '0;
            end
        end else begin
            r_crit_valid <= 1'b0;
            if (w_accept) begin
                r_offset <= fill_addr[LSB-1:BW];
                r_base   <= fill_addr[AW-1:LSB];
                r_cnt    <= '0;
            end
            if (w_beat) begin
                r_line[w_idx] <= mem_rdata;
                r_cnt         <= r_cnt + 1'b1;
                if (r_cnt == '0) begin
                    r_crit_word  <= mem_rdata;
                    r_crit_valid <= 1'b1;
                end
            end
        end
    end

    assign mem_addr   = {r_base, r_offset, {BW{1'b0}}};
    assign line_addr  = {r_base, {LSB{1'b0}}};
    assign crit_word  = r_crit_word;
    assign crit_valid = r_crit_valid;

    generate
        for (genvar k = 0; k < WORDS; k++) begin : g_line_flat
            assign line_data[DW*k +: DW] = r_line[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_line_fill_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_fill_buffer
// Brief    : Directed + randomized bench for line_fill_buffer against a
//            line-level reference model (word (offset+k) mod 8 = beat k).
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_fill_buffer;

    localparam int WORDS = 8;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LW    = WORDS * DW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          fill_start;
    logic [AW-1:0] fill_addr;
    logic          fill_busy;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rdy;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          crit_valid;
    logic [DW-1:0] crit_word;
    logic          line_valid;
    logic [LW-1:0] line_data;
    logic [AW-1:0] line_addr;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DW-1:0] exp_line [WORDS];
    logic [AW-1:0] exp_line_addr;

    always #5 clk = ~clk;

    line_fill_buffer #(.WORDS(WORDS), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_busy  (fill_busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdy    (mem_rdy),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .crit_valid (crit_valid),
        .crit_word  (crit_word),
        .line_valid (line_valid),
        .line_data  (line_data),
        .line_addr  (line_addr)
    );

    function automatic logic [LW-1:0] packed_line();
        logic [LW-1:0] v;
        for (int k = 0; k < WORDS; k++) v[DW*k +: DW] = exp_line[k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fill: accept, request handshake, burst with optional gaps,
    // optional fill_start interference during the burst, then line delivery.
    task automatic do_fill(input logic [AW-1:0] addr, input int rdy_delay,
                           input int min_gap, input int max_gap, input bit interfere,
                           input bit fixed_data, input logic [DW-1:0] base_val);
        logic [DW-1:0] beats [WORDS];
        int            off;
        int            gaps;
        int            extra_crit;
        int            extra_line;
        logic [AW-1:0] exp_mem_addr;
        off          = int'(addr[4:2]);
        exp_mem_addr = {addr[AW-1:2], 2'b00};
        extra_crit   = 0;
        extra_line   = 0;
        for (int k = 0; k < WORDS; k++) beats[k] = fixed_data ? base_val + DW'(k) : DW'($urandom);

        check("busy_before_start", fill_busy, 0);
        fill_start = 1'b1;
        fill_addr  = addr;
        tick();
        fill_start = 1'b0;
        fill_addr  = $urandom;
        exp_line_addr = {addr[AW-1:5], 5'b0};
        check("busy_after_accept", fill_busy, 1);
        check("mem_req_up", mem_req, 1);
        check("mem_addr", mem_addr, exp_mem_addr);
        check("line_addr_accept", line_addr, exp_line_addr);

        // Hold off the handshake; stray read data here must be ignored.
        for (int i = 0; i < rdy_delay; i++) begin
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            tick();
            check("mem_req_hold", mem_req, 1);
            check("mem_addr_hold", mem_addr, exp_mem_addr);
        end
        mem_rvalid = 1'b0;
        mem_rdy    = 1'b1;
        tick();
        mem_rdy    = 1'b0;
        check("mem_req_drop", mem_req, 0);

        for (int k = 0; k < WORDS; k++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(min_gap, max_gap)) : 0;
            if (interfere && k == 4 && gaps == 0) gaps = 1;
            for (int g = 0; g < gaps; g++) begin
                if (interfere && k == 4 && g == 0) begin
                    fill_start = 1'b1;
                    fill_addr  = addr ^ 32'h0001_0040;
                end
                mem_rdata = $urandom;
                tick();
                fill_start = 1'b0;
                if (crit_valid) extra_crit++;
                if (line_valid) extra_line++;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beats[k];
            tick();
            mem_rvalid = 1'b0;
            exp_line[(off + k) % WORDS] = beats[k];
            if (k == 0) begin
                check("crit_valid", crit_valid, 1);
                check("crit_word", crit_word, beats[0]);
            end else if (crit_valid) begin
                extra_crit++;
            end
            if (k < WORDS - 1 && line_valid) extra_line++;
        end

        check("line_valid_pulse", line_valid, 1);
        check("line_data", line_data, packed_line());
        check("busy_in_done", fill_busy, 1);
        check("line_addr_done", line_addr, exp_line_addr);
        tick();
        check("line_valid_drop", line_valid, 0);
        check("busy_drop", fill_busy, 0);
        check("line_data_hold", line_data, packed_line());
        check("extra_crit_pulses", extra_crit, 0);
        check("extra_line_pulses", extra_line, 0);
    endtask

    initial begin
        logic [LW-1:0] zero_line;
        logic [LW-1:0] first_line;
        logic [AW-1:0] ra;
        zero_line  = '0;
        resetn     = 1'b0;
        fill_start = 1'b0;
        fill_addr  = '0;
        mem_rdy    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int k = 0; k < WORDS; k++) exp_line[k] = '0;
        exp_line_addr = '0;
        tick();
        tick();
        resetn = 1'b1;

        // Reset state
        check("rst_busy", fill_busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_crit_valid", crit_valid, 0);
        check("rst_crit_word", crit_word, 0);
        check("rst_line_valid", line_valid, 0);
        check("rst_line_data", line_data, zero_line);
        check("rst_line_addr", line_addr, 0);

        // Aligned fill, immediate ready, back-to-back beats
        do_fill(32'h0000_1000, 0, 0, 0, 1'b0, 1'b1, 32'hA0);
        first_line = packed_line();
        check("t1_word3", line_data[DW*3 +: DW], 32'hA3);

        // Offset 7 wraps: word7 first, then 0..6
        do_fill(32'h0000_201C, 0, 0, 0, 1'b0, 1'b1, 32'hB0);
        check("t2_word7", line_data[DW*7 +: DW], 32'hB0);
        check("t2_word0", line_data[DW*0 +: DW], 32'hB1);
        check("t2_word6", line_data[DW*6 +: DW], 32'hB7);
        check("t2_line_addr", line_addr, 32'h0000_2000);

        // Delayed ready and gapped beats give the same line as test 1
        do_fill(32'h0000_1000, 5, 1, 2, 1'b0, 1'b1, 32'hA0);
        check("t3_same_line", line_data, first_line);

        // fill_start during RECV ignored; next fill accepted once idle
        do_fill(32'h0000_4010, 2, 1, 2, 1'b1, 1'b0, 32'h0);
        check("t4_line_addr", line_addr, 32'h0000_4000);
        do_fill(32'h0000_5004, 1, 0, 1, 1'b0, 1'b0, 32'h0);

        // Abort mid-burst with reset, then stray beats
        fill_start = 1'b1;
        fill_addr  = 32'h0000_3008;
        tick();
        fill_start = 1'b0;
        mem_rdy    = 1'b1;
        tick();
        mem_rdy    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hC0 + k;
            tick();
        end
        mem_rvalid = 1'b0;
        resetn     = 1'b0;
        tick();
        resetn     = 1'b1;
        for (int k = 0; k < WORDS; k++) exp_line[k] = '0;
        check("abort_busy", fill_busy, 0);
        check("abort_line_data", line_data, zero_line);
        check("abort_line_addr", line_addr, 0);
        for (int k = 0; k < 5; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            tick();
            check("stray_crit", crit_valid, 0);
            check("stray_line", line_valid, 0);
            check("stray_busy", fill_busy, 0);
        end
        mem_rvalid = 1'b0;
        check("stray_line_data", line_data, zero_line);
        do_fill(32'h0000_3008, 0, 0, 0, 1'b0, 1'b1, 32'hD0);

        // Randomized fills
        for (int n = 0; n < 8; n++) begin
            ra = $urandom;
            do_fill(ra, int'($urandom_range(0, 3)), 0, 2, 1'(n % 3 == 0), 1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
